// File: rtl/cbuf_fifo.sv
// cbuf_fifo: joined data/control input feeding a pass-or-drop FIFO with a per-token completion channel
module cbuf_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int C_EN  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       ctl_valid,
    output logic                       ctl_ready,
    input  logic                       ctl_pass,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       c_valid,
    input  logic                       c_ready,
    output logic                       c_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cv_q, cv_d, cd_q, cd_d;
    logic             pop, push, fire, go, f_free, c_free;

    // join of in/ctl, gated by FIFO room (pass tokens only) and a free completion slot
    always_comb begin
        pop       = (cnt_q != '0) & out_ready;
        f_free    = (cnt_q < CW'(DEPTH)) | pop;
        c_free    = (C_EN == 0) | ~cv_q | c_ready;
        go        = reset & c_free & (ctl_pass ? f_free : 1'b1);
        fire      = in_valid & ctl_valid & go;
        push      = fire & ctl_pass;
        in_ready  = ctl_valid & go;
        ctl_ready = in_valid & go;
        rd_d      = pop ? ((rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1)) : rd_q;
        wr_d      = push ? ((wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1)) : wr_q;
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        cv_d      = (C_EN != 0) & (fire | (cv_q & ~c_ready));
        cd_d      = (C_EN != 0) & (fire ? ctl_pass : cd_q);
        out_valid = cnt_q != '0;
        out_data  = mem_q[rd_q];
        c_valid   = cv_q;
        c_data    = cd_q;
        count     = cnt_q;
    end

    // state registers; reset also zeroes storage so out_data reads 0 until the first push
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            cv_q  <= 1'b0;
            cd_q  <= 1'b0;
        end else begin
            if (push) mem_q[wr_q] <= in_data;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            cv_q  <= cv_d;
            cd_q  <= cd_d;
        end
    end
endmodule

// File: tb/tb_cbuf_fifo.sv
// tb_cbuf_fifo: queue-based model check of two cbuf_fifo configurations plus directed scenarios
module tb_cbuf_fifo;
    logic       clk, reset, in_valid, ctl_valid, ctl_pass, out_ready, c_ready;
    logic [7:0] in_data;
    logic       ir[2], cr[2], ov[2], cvo[2], cdo[2];
    logic [7:0] od[2];
    logic [2:0] cnt0;
    logic [1:0] cnt1;

    int total = 0, bad = 0, inx = 0, ctx = 0;
    int dep[2] = '{4, 3};
    bit cen[2] = '{1'b1, 1'b0};
    logic [7:0] mq[2][$];
    bit cv[2], cd[2], fresh[2];
    logic [7:0] olog[$];
    logic       clog[$];
    logic [7:0] exp3[12] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1,
                             8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7};

    cbuf_fifo #(.WIDTH(8), .DEPTH(4), .C_EN(1)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .ctl_valid(ctl_valid), .ctl_ready(cr[0]), .ctl_pass(ctl_pass), .out_valid(ov[0]),
        .out_ready(out_ready), .out_data(od[0]), .c_valid(cvo[0]), .c_ready(c_ready),
        .c_data(cdo[0]), .count(cnt0));

    cbuf_fifo #(.WIDTH(8), .DEPTH(3), .C_EN(0)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .ctl_valid(ctl_valid), .ctl_ready(cr[1]), .ctl_pass(ctl_pass), .out_valid(ov[1]),
        .out_ready(out_ready), .out_data(od[1]), .c_valid(cvo[1]), .c_ready(c_ready),
        .c_data(cdo[1]), .count(cnt1));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, a, e, $time);
        end
    endtask

    // may instance k accept a token pair right now (rules from the channel definitions)
    function automatic bit okf(int k);
        bit cf = cen[k] ? (!cv[k] || c_ready) : 1'b1;
        bit ff = (mq[k].size() < dep[k]) || (mq[k].size() > 0 && out_ready);
        return reset && cf && (ctl_pass ? ff : 1'b1);
    endfunction

    // behavioural model: token queue plus pending completion per instance
    always @(posedge clk) begin
        bit f;
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                mq[k].delete();
                cv[k] = 0;
                cd[k] = 0;
                fresh[k] = 1;
            end else begin
                f = in_valid && ctl_valid && okf(k);
                if (mq[k].size() > 0 && out_ready) void'(mq[k].pop_front());
                if (f && ctl_pass) begin
                    mq[k].push_back(in_data);
                    fresh[k] = 0;
                end
                if (cen[k]) begin
                    if (f) begin
                        cv[k] = 1;
                        cd[k] = ctl_pass;
                    end else if (c_ready) cv[k] = 0;
                end
            end
        end
    end

    // per-cycle compare and transfer logging, away from the active edge
    always @(negedge clk) begin
        bit o;
        logic [2:0] cn;
        for (int k = 0; k < 2; k++) begin
            o  = okf(k);
            cn = (k == 0) ? cnt0 : {1'b0, cnt1};
            chk($sformatf("in_ready%0d", k), ir[k], ctl_valid && o);
            chk($sformatf("ctl_ready%0d", k), cr[k], in_valid && o);
            chk($sformatf("count%0d", k), cn, mq[k].size());
            chk($sformatf("out_valid%0d", k), ov[k], mq[k].size() != 0);
            chk($sformatf("c_valid%0d", k), cvo[k], cv[k]);
            chk($sformatf("c_data%0d", k), cdo[k], cd[k]);
            if (mq[k].size() > 0) chk($sformatf("out_data%0d", k), od[k], mq[k][0]);
            else if (fresh[k]) chk($sformatf("out_data_rst%0d", k), od[k], 0);
            if (in_valid && ir[k]) inx++;
            if (ctl_valid && cr[k]) ctx++;
        end
        if (ov[0] && out_ready) olog.push_back(od[0]);
        if (cvo[0] && c_ready) clog.push_back(cdo[0]);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic p);
        in_data = d;
        ctl_pass = p;
        in_valid = 1;
        ctl_valid = 1;
        #1;
        for (int n = 0; n < 20 && !ir[0]; n++) cyc(1);
        chk("send_ready", ir[0], 1);
        cyc(1);
        in_valid = 0;
        ctl_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        reset = 0; in_valid = 0; ctl_valid = 0; ctl_pass = 0; in_data = 0;
        out_ready = 0; c_ready = 0;
        cyc(3);
        chk("rst_count", cnt0, 0);
        chk("rst_out_valid", ov[0], 0);
        chk("rst_out_data", od[0], 0);
        chk("rst_in_ready", ir[0], 0);
        // pass/drop basic flow, first fire right after reset release
        reset = 1; out_ready = 1; c_ready = 1;
        olog.delete(); clog.delete();
        send(8'h11, 1); send(8'h22, 0); send(8'h33, 1);
        cyc(4);
        chk("t1_olen", olog.size(), 2);
        chk("t1_o0", olog[0], 8'h11);
        chk("t1_o1", olog[1], 8'h33);
        chk("t1_clen", clog.size(), 3);
        chk("t1_c0", clog[0], 1);
        chk("t1_c1", clog[1], 0);
        chk("t1_c2", clog[2], 1);
        chk("t1_count", cnt0, 0);
        // fill with out stalled; a drop token still goes through
        out_ready = 0;
        clog.delete();
        for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 1);
        chk("t2_full", cnt0, 4);
        in_valid = 1; ctl_valid = 1; ctl_pass = 1; in_data = 8'h99;
        #1;
        chk("t2_block_pass", ir[0], 0);
        ctl_pass = 0;
        #1;
        chk("t2_drop_ok", ir[0], 1);
        send(8'h55, 0);
        cyc(2);
        chk("t2_clen", clog.size(), 5);
        chk("t2_cdrop", clog[4], 0);
        chk("t2_count", cnt0, 4);
        // full FIFO streaming across pointer wrap
        olog.delete();
        out_ready = 1; in_valid = 1; ctl_valid = 1; ctl_pass = 1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'hB0 + 8'(i);
            #1;
            chk("t3_ready", ir[0], 1);
            chk("t3_count", cnt0, 4);
            @(posedge clk);
            #1;
        end
        in_valid = 0; ctl_valid = 0;
        cyc(6);
        chk("t3_olen", olog.size(), 12);
        for (int i = 0; i < 12; i++) chk($sformatf("t3_o%0d", i), olog[i], exp3[i]);
        // completion backpressure blocks fires until the c transfer
        olog.delete(); clog.delete();
        c_ready = 0;
        send(8'h61, 1);
        in_data = 8'h62; ctl_pass = 1; in_valid = 1; ctl_valid = 1;
        #1;
        chk("t4_in_blk", ir[0], 0);
        chk("t4_ctl_blk", cr[0], 0);
        cyc(3);
        chk("t4_in_blk2", ir[0], 0);
        c_ready = 1;
        #1;
        chk("t4_release", ir[0], 1);
        cyc(1);
        in_valid = 0; ctl_valid = 0;
        chk("t4_cv", cvo[0], 1);
        chk("t4_cd", cdo[0], 1);
        cyc(3);
        chk("t4_clen", clog.size(), 2);
        chk("t4_olen", olog.size(), 2);
        chk("t4_o1", olog[1], 8'h62);
        // one-sided valid never transfers
        inx = 0; ctx = 0;
        in_valid = 1;
        cyc(10);
        in_valid = 0; ctl_valid = 1;
        cyc(10);
        ctl_valid = 0;
        chk("t5_in_xfer", inx, 0);
        chk("t5_ctl_xfer", ctx, 0);
        // reset mid-operation
        out_ready = 0; c_ready = 1;
        send(8'h71, 1); send(8'h72, 1); send(8'h73, 1);
        c_ready = 0;
        chk("t6_count", cnt0, 3);
        chk("t6_cv", cvo[0], 1);
        reset = 0;
        cyc(1);
        chk("t6_rcount", cnt0, 0);
        chk("t6_rov", ov[0], 0);
        chk("t6_rcv", cvo[0], 0);
        chk("t6_rod", od[0], 0);
        chk("t6_rcv1", cvo[1], 0);
        chk("t6_rcount1", cnt1, 0);
        reset = 1;
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
